// File: rtl/seq_detector_param.sv
// seq_detector_param: runtime-loadable serial pattern detector with Mealy match pulse; SEQ_DET_MATCH_CNT_EN adds a saturating match counter
module seq_detector_param #(
  parameter int                   PAT_LEN     = 4,
  parameter logic [PAT_LEN-1:0]   RST_PATTERN = 4'b1010,
  parameter int                   CNT_W       = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               din,
  input  logic               din_valid,
  input  logic               overlap,
  input  logic               pat_load,
  input  logic [PAT_LEN-1:0] pat_in,
  output logic               dout,
  output logic               busy
`ifdef SEQ_DET_MATCH_CNT_EN
  ,output logic [CNT_W-1:0]  match_cnt
`endif
);
  localparam int FW = $clog2(PAT_LEN);
  localparam logic [FW-1:0] ARMED = FW'(PAT_LEN - 1);
  if (PAT_LEN < 2 || PAT_LEN > 32 || CNT_W < 1) begin : g_bad_param
    $error("seq_detector_param: PAT_LEN must be 2..32 and CNT_W >= 1");
  end
  logic [PAT_LEN-2:0] hist_q, hist_d;
  logic [FW-1:0]      fill_q, fill_d;
  logic [PAT_LEN-1:0] pat_q, pat_d, cand;
  logic               busy_q, hit, flush;
  assign cand  = {hist_q, din};
  assign hit   = din_valid & ~pat_load & (fill_q == ARMED) & (cand == pat_q);
  assign flush = pat_load | (hit & ~overlap);
  // state register: history, fill level (the FSM state), pattern and busy flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      fill_q <= '0;
      pat_q  <= RST_PATTERN;
      busy_q <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      pat_q  <= pat_d;
      busy_q <= fill_d != '0;
    end
  end
  // next state: load/non-overlap match restart, valid bits shift in and fill saturates at armed
  always_comb begin
    pat_d  = pat_load ? pat_in : pat_q;
    hist_d = flush ? '0 : din_valid ? cand[PAT_LEN-2:0] : hist_q;
    fill_d = flush ? '0 : !din_valid ? fill_q : (fill_q == ARMED) ? ARMED : fill_q + 1'b1;
  end
  // outputs: zero-latency Mealy match and registered busy
  always_comb begin
    dout = hit;
    busy = busy_q;
  end
`ifdef SEQ_DET_MATCH_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // match counter: cleared by a pattern load, saturates at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  // counter next value
  always_comb cnt_d = pat_load ? '0 : (hit && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  assign match_cnt = cnt_q;
`endif
endmodule

// File: tb/tb_seq_detector_param.sv
// tb_seq_detector_param: directed self-checking bench for seq_detector_param
module tb_seq_detector_param;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din = 1'b0;
  logic       din_valid = 1'b0;
  logic       overlap = 1'b0;
  logic       pat_load = 1'b0;
  logic [3:0] pat_in = 4'b0000;
  logic       dout, busy;
`ifdef SEQ_DET_MATCH_CNT_EN
  logic [1:0] match_cnt;
`endif
  int checks = 0;
  int errors = 0;

  seq_detector_param #(.PAT_LEN(4), .RST_PATTERN(4'b1010), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .overlap(overlap),
    .pat_load(pat_load), .pat_in(pat_in), .dout(dout), .busy(busy)
`ifdef SEQ_DET_MATCH_CNT_EN
    ,.match_cnt(match_cnt)
`endif
  );

  always #5 clk = ~clk;

  // one cycle of stimulus; dout captured on the falling edge, returns 1 time unit after the rising edge
  task automatic step(input logic v, input logic b, input logic ld, input logic [3:0] p, output logic d);
    din_valid = v; din = b; pat_load = ld; pat_in = p;
    @(negedge clk);
    d = dout;
    @(posedge clk);
    #1;
    din_valid = 1'b0; pat_load = 1'b0; din = 1'b0;
  endtask

  // n valid bits, bits[n-1] first; got[n-1] is dout of the first bit
  task automatic feed(input int n, input logic [7:0] bits, output logic [7:0] got);
    logic d;
    got = '0;
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, bits[i], 1'b0, 4'b0000, d);
      got[i] = d;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; din_valid = 1'b0; pat_load = 1'b0; din = 1'b0;
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; din = 1'b1; din_valid = 1'b1;
    #2;
    checks++;
    if (dout !== 1'b0) begin errors++; $display("FAIL reset_dout got=%b exp=0", dout); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
`ifdef SEQ_DET_MATCH_CNT_EN
    checks++;
    if (match_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got=%0d exp=0", match_cnt); end
`endif
    do_reset();
  endtask

  task automatic test_nonoverlap();
    logic [7:0] got;
    do_reset();
    overlap = 1'b0;
    feed(4, 8'b0000_1010, got);
    checks++;
    if (got[3:0] !== 4'b0001) begin errors++; $display("FAIL nonovl_first got=%b exp=0001", got[3:0]); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL nonovl_busy_after_match got=%b exp=0", busy); end
    feed(2, 8'b0000_0010, got);
    checks++;
    if (got[1:0] !== 2'b00) begin errors++; $display("FAIL nonovl_no_reuse got=%b exp=00", got[1:0]); end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL nonovl_busy_partial got=%b exp=1", busy); end
  endtask

  task automatic test_overlap();
    logic [7:0] got;
    do_reset();
    overlap = 1'b1;
    feed(6, 8'b0010_1010, got);
    checks++;
    if (got[5:0] !== 6'b000101) begin errors++; $display("FAIL ovl_101010 got=%b exp=000101", got[5:0]); end
`ifdef SEQ_DET_MATCH_CNT_EN
    checks++;
    if (match_cnt !== 2'd2) begin errors++; $display("FAIL ovl_cnt got=%0d exp=2", match_cnt); end
`endif
  endtask

  task automatic test_pat_load();
    logic [7:0] got;
    logic d;
    overlap = 1'b1;
    step(1'b1, 1'b1, 1'b1, 4'b1111, d);
    checks++;
    if (d !== 1'b0) begin errors++; $display("FAIL load_dout got=%b exp=0", d); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL load_busy got=%b exp=0", busy); end
`ifdef SEQ_DET_MATCH_CNT_EN
    checks++;
    if (match_cnt !== 2'd0) begin errors++; $display("FAIL load_cnt_clear got=%0d exp=0", match_cnt); end
`endif
    feed(6, 8'b0011_1111, got);
    checks++;
    if (got[5:0] !== 6'b000111) begin errors++; $display("FAIL ones_ovl got=%b exp=000111", got[5:0]); end
    overlap = 1'b0;
    step(1'b0, 1'b0, 1'b1, 4'b1111, d);
    feed(6, 8'b0011_1111, got);
    checks++;
    if (got[5:0] !== 6'b000100) begin errors++; $display("FAIL ones_nonovl got=%b exp=000100", got[5:0]); end
  endtask

  task automatic test_valid_gap();
    logic [7:0] got;
    logic d;
    do_reset();
    overlap = 1'b0;
    feed(3, 8'b0000_0101, got);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 1'b0, 4'b0000, d);
      checks++;
      if (d !== 1'b0) begin errors++; $display("FAIL gap_dout cyc%0d got=%b exp=0", i, d); end
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL gap_busy got=%b exp=1", busy); end
    feed(1, 8'b0000_0000, got);
    checks++;
    if (got[0] !== 1'b1) begin errors++; $display("FAIL gap_resume got=%b exp=1", got[0]); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] got;
    logic d;
    do_reset();
    overlap = 1'b0;
    feed(3, 8'b0000_0101, got);
    din = 1'b0; din_valid = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (dout !== 1'b0) begin errors++; $display("FAIL midrst_dout got=%b exp=0", dout); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    rst = 1'b0;
    @(negedge clk);
    d = dout;
    @(posedge clk);
    #1;
    din_valid = 1'b0;
    checks++;
    if (d !== 1'b0) begin errors++; $display("FAIL midrst_no_match got=%b exp=0", d); end
    feed(4, 8'b0000_1010, got);
    checks++;
    if (got[3:0] !== 4'b0001) begin errors++; $display("FAIL midrst_fresh got=%b exp=0001", got[3:0]); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] got;
    logic d;
    overlap = 1'b1;
    step(1'b0, 1'b0, 1'b1, 4'b1111, d);
    feed(8, 8'b1111_1111, got);
    checks++;
    if (got !== 8'b0001_1111) begin errors++; $display("FAIL b2b_ones got=%b exp=00011111", got); end
`ifdef SEQ_DET_MATCH_CNT_EN
    checks++;
    if (match_cnt !== 2'd3) begin errors++; $display("FAIL cnt_saturate got=%0d exp=3", match_cnt); end
    step(1'b0, 1'b0, 1'b1, 4'b1010, d);
    checks++;
    if (match_cnt !== 2'd0) begin errors++; $display("FAIL cnt_clear got=%0d exp=0", match_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_nonoverlap();
    test_overlap();
    test_pat_load();
    test_valid_gap();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
